// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: the 2-bit counter
// encoding, the fetch opcode that marks control flow, and the saturating
// counter update.
package branch_predictor_pkg;

  typedef logic [1:0] counter_t;

  localparam counter_t SNT = 2'b00;  // strongly not-taken
  localparam counter_t WNT = 2'b01;  // weakly not-taken
  localparam counter_t WT  = 2'b10;  // weakly taken
  localparam counter_t ST  = 2'b11;  // strongly taken

  // Counters come out of reset biased slightly towards not-taken.
  localparam counter_t PHT_RESET = WNT;

  // opcode[6:5] == 2'b11 covers branch, jal and jalr.
  localparam logic [1:0] OP_CTRL_FLOW = 2'b11;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic counter_t next_counter(input counter_t cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : counter_t'(cnt + 2'd1);
    end
    return (cnt == SNT) ? SNT : counter_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side and EX-side signal bundle between the pipeline and the
// branch predictor. The pipeline holds the master view, the predictor
// the slave view.
interface branch_predictor_if #(
  parameter int GHR_W = 6
);

  // fetch stage
  logic [31:0]      pc_fi_i;
  logic [1:0]       op_fi_i;
  logic             stall_fi_i;
  logic             pc_src_pred_fi_o;
  logic [GHR_W-1:0] ghr_fi_o;

  // execute stage
  logic [31:0]      pc_ex_i;
  logic [GHR_W-1:0] ghr_ex_i;
  logic [1:0]       branch_op_ex_i;
  logic             pc_src_pred_ex_i;
  logic             pc_src_res_ex_i;
  logic             stall_ex_i;

  modport master (
    output pc_fi_i, op_fi_i, stall_fi_i,
    output pc_ex_i, ghr_ex_i, branch_op_ex_i, pc_src_pred_ex_i, pc_src_res_ex_i, stall_ex_i,
    input  pc_src_pred_fi_o, ghr_fi_o
  );

  modport slave (
    input  pc_fi_i, op_fi_i, stall_fi_i,
    input  pc_ex_i, ghr_ex_i, branch_op_ex_i, pc_src_pred_ex_i, pc_src_res_ex_i, stall_ex_i,
    output pc_src_pred_fi_o, ghr_fi_o
  );

endinterface

// File: rtl/branch_predictor_pht_bank.sv
// Pattern history table: 2**IDX_W two-bit counters with two combinational
// read ports (fetch prediction, EX read-modify-write) and one synchronous
// write port. Reset re-initialises every entry, so this is register storage
// rather than block RAM.
module branch_predictor_pht_bank
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IDX_W-1:0] rd_idx_a,
  output counter_t         rd_data_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output counter_t         rd_data_b,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  counter_t         wr_data
);

  localparam int ENTRIES = 1 << IDX_W;

  counter_t mem [ENTRIES];

  // Reads see the pre-write contents; a same-cycle write lands at the edge.
  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];

  // Reset all counters together; otherwise apply the single training write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= PHT_RESET;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor. Fetch indexes the PHT with PC xor GHR and
// speculatively shifts its own prediction into the GHR; EX trains the
// indexed counter on resolved conditional branches and rebuilds the GHR
// from the instruction's snapshot when the prediction was wrong.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6
) (
  input logic               clk_i,
  input logic               reset_i,
  branch_predictor_if.slave bp
);

  logic [GHR_W-1:0]     ghr_reg;
  logic [PHT_IDX_W-1:0] idx_fi;
  logic [PHT_IDX_W-1:0] idx_ex;
  counter_t             cnt_fi;
  counter_t             cnt_ex;
  logic                 ctrl_fi;
  logic                 pred_fi;
  logic                 train_ex;
  logic                 mispredict_ex;

  // History is zero-extended up to the index width before hashing.
  assign idx_fi = bp.pc_fi_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_reg);
  assign idx_ex = bp.pc_ex_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bp.ghr_ex_i);

  assign ctrl_fi = (bp.op_fi_i == OP_CTRL_FLOW);
  assign pred_fi = ctrl_fi & cnt_fi[1];

  // Only conditional branches train; jal/jalr target errors belong to branch control.
  assign train_ex      = bp.branch_op_ex_i[0] & ~bp.stall_ex_i;
  assign mispredict_ex = train_ex & (bp.pc_src_pred_ex_i != bp.pc_src_res_ex_i);

  assign bp.pc_src_pred_fi_o = pred_fi;
  assign bp.ghr_fi_o         = ghr_reg;

  branch_predictor_pht_bank #(
    .IDX_W (PHT_IDX_W)
  ) u_pht (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rd_idx_a  (idx_fi),
    .rd_data_a (cnt_fi),
    .rd_idx_b  (idx_ex),
    .rd_data_b (cnt_ex),
    .wr_en     (train_ex),
    .wr_idx    (idx_ex),
    .wr_data   (next_counter(cnt_ex, bp.pc_src_res_ex_i))
  );

  // GHR: repair from the EX snapshot on mispredict (the fetch in flight is
  // flushed), otherwise shift in the fetch prediction for unstalled control flow.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ghr_reg <= '0;
    end else if (mispredict_ex) begin
      ghr_reg <= {bp.ghr_ex_i[GHR_W-2:0], bp.pc_src_res_ex_i};
    end else if (ctrl_fi && !bp.stall_fi_i) begin
      ghr_reg <= {ghr_reg[GHR_W-2:0], pred_fi};
    end
  end

  // Address bits outside the index window and the unconditional-op bit are not needed.
  logic unused_ok;
  assign unused_ok = ^{bp.pc_fi_i[31:PHT_IDX_W+2], bp.pc_fi_i[1:0],
                       bp.pc_ex_i[31:PHT_IDX_W+2], bp.pc_ex_i[1:0],
                       bp.branch_op_ex_i[1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for the gshare predictor: a table-of-integers model of the
// PHT and history, compared against the DUT every cycle, plus literal
// expectations at the interesting points of the sequence.
module tb_branch_predictor;

  localparam int IDXW = 6;
  localparam int GW   = 6;
  localparam int NPHT = 1 << IDXW;
  localparam int NGHR = 1 << GW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.GHR_W(GW)) bif ();

  branch_predictor #(
    .PHT_IDX_W (IDXW),
    .GHR_W     (GW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bp      (bif)
  );

  int model_pht [NPHT];
  int model_ghr;
  int n_vec   = 0;
  int n_err   = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Prediction the model expects for the current fetch inputs.
  function automatic int model_pred();
    int idx;
    if (bif.op_fi_i != 2'b11) return 0;
    idx = ((int'(bif.pc_fi_i) / 4) % NPHT) ^ model_ghr;
    return (model_pht[idx] >= 2) ? 1 : 0;
  endfunction

  // Model state update at each rising edge.
  always @(posedge clk) begin
    int  pf;
    int  ie;
    bit  trn;
    bit  mis;
    if (reset) begin
      for (int i = 0; i < NPHT; i++) model_pht[i] = 1;
      model_ghr = 0;
    end else begin
      pf  = model_pred();
      trn = (int'(bif.branch_op_ex_i) % 2 == 1) && !bif.stall_ex_i;
      mis = trn && (bif.pc_src_pred_ex_i != bif.pc_src_res_ex_i);
      if (trn) begin
        ie = ((int'(bif.pc_ex_i) / 4) % NPHT) ^ int'(bif.ghr_ex_i);
        if (bif.pc_src_res_ex_i) model_pht[ie] = (model_pht[ie] < 3) ? model_pht[ie] + 1 : 3;
        else                     model_pht[ie] = (model_pht[ie] > 0) ? model_pht[ie] - 1 : 0;
      end
      if (mis)
        model_ghr = (int'(bif.ghr_ex_i) * 2 + int'(bif.pc_src_res_ex_i)) % NGHR;
      else if (bif.op_fi_i == 2'b11 && !bif.stall_fi_i)
        model_ghr = (model_ghr * 2 + pf) % NGHR;
    end
  end

  // Per-cycle comparison, on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      check("cyc_pred", bif.pc_src_pred_fi_o, model_pred());
      check("cyc_ghr", bif.ghr_fi_o, model_ghr);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic fetch(input int pc, input int op, input bit stall);
    bif.pc_fi_i    = 32'(pc);
    bif.op_fi_i    = 2'(op);
    bif.stall_fi_i = stall;
  endtask

  task automatic ex(input int bop, input int pc, input int ghr, input bit pred, input bit res, input bit stall);
    bif.branch_op_ex_i   = 2'(bop);
    bif.pc_ex_i          = 32'(pc);
    bif.ghr_ex_i         = GW'(ghr);
    bif.pc_src_pred_ex_i = pred;
    bif.pc_src_res_ex_i  = res;
    bif.stall_ex_i       = stall;
  endtask

  initial begin
    fetch(0, 0, 0);
    ex(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    run_cmp = 1'b1;

    // Reset state and first fetch lookup.
    fetch('h100, 3, 1);
    #1;
    check("reset_pred", bif.pc_src_pred_fi_o, 0);
    check("reset_ghr", bif.ghr_fi_o, 0);
    check("model_reset_cnt", model_pht[17], 1);
    for (int i = 0; i < NPHT; i++) begin
      fetch(i * 4, 3, 1);
      tick();
    end

    // Three taken resolutions at 0x100 / ghr 0 -> 2, 3, 3.
    fetch(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      ex(1, 'h100, 0, 1, 1, 0);
      tick();
      check("train_up", model_pht[0], (k == 0) ? 2 : 3);
    end
    ex(0, 0, 0, 0, 0, 0);
    fetch('h100, 3, 1);
    tick();
    check("pred_after_up", bif.pc_src_pred_fi_o, 1);

    // Four not-taken resolutions -> 2, 1, 0, 0.
    fetch(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ex(1, 'h100, 0, 0, 0, 0);
      tick();
      check("train_down", model_pht[0], (k < 3) ? 2 - k : 0);
    end
    ex(0, 0, 0, 0, 0, 0);
    fetch('h100, 3, 1);
    tick();
    check("pred_after_down", bif.pc_src_pred_fi_o, 0);

    // Make entry 1 strongly taken for the history sequence.
    fetch(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      ex(1, 'h104, 0, 1, 1, 0);
      tick();
    end
    ex(0, 0, 0, 0, 0, 0);

    // Speculative history: predictions 1, (stall), 0, 1.
    fetch('h104, 3, 0); tick(); check("ghr_shift1", bif.ghr_fi_o, 1);
    fetch('h100, 3, 1); tick(); check("ghr_stall", bif.ghr_fi_o, 1);
    fetch('h104, 3, 0); tick(); check("ghr_shift0", bif.ghr_fi_o, 2);
    fetch('h10C, 3, 0); tick(); check("ghr_shift1b", bif.ghr_fi_o, 5);

    // Mispredict repair beats the same-cycle fetch shift.
    ex(1, 'h200, 3, 1, 0, 0);
    fetch('h104, 3, 0);
    tick();
    check("ghr_repair", bif.ghr_fi_o, 6);
    ex(0, 0, 0, 0, 0, 0);
    fetch(0, 0, 0);

    // EX stall: no training, no repair.
    ex(1, 'h110, 0, 0, 1, 1);
    tick();
    check("ghr_ex_stall", bif.ghr_fi_o, 6);
    check("model_no_train", model_pht[4], 1);
    ex(0, 0, 0, 0, 0, 0);
    fetch('h108, 3, 1);
    tick();
    check("pred_ex_stall", bif.pc_src_pred_fi_o, 0);

    // Both stages stalled: full hold.
    ex(1, 'h110, 0, 0, 1, 1);
    fetch('h104, 3, 1);
    tick();
    check("ghr_both_stall", bif.ghr_fi_o, 6);

    // Same-cycle read and write of entry 4: fetch sees the old counter.
    ex(1, 'h110, 0, 1, 1, 0);
    fetch('h108, 3, 1);
    #1;
    check("no_bypass_pre", bif.pc_src_pred_fi_o, 0);
    tick();
    ex(0, 0, 0, 0, 0, 0);
    #1;
    check("post_write", bif.pc_src_pred_fi_o, 1);

    // Reset in the middle of training and a fetch shift.
    ex(1, 'h104, 0, 0, 1, 0);
    fetch('h104, 3, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex(0, 0, 0, 0, 0, 0);
    fetch('h104, 3, 1);
    #1;
    check("rst_mid_ghr", bif.ghr_fi_o, 0);
    check("rst_mid_pred", bif.pc_src_pred_fi_o, 0);
    check("model_rst_mid", model_pht[1], 1);
    for (int i = 0; i < NPHT; i++) begin
      fetch(i * 4, 3, 1);
      tick();
    end

    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
